// File: rtl/cim_seq_if.sv
// Request/result handshake bundle between the level quantiser, the CiM
// sequencer and the HV datapath.
interface cim_seq_if #(
  parameter int unsigned HVDimension  = 512,
  parameter int unsigned SeedWidth    = 32,
  parameter int unsigned NumCimLevels = HVDimension / 2
);
  localparam int unsigned LevelWidth = $clog2(NumCimLevels);

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [SeedWidth-1:0]   seed_hv_i;
  logic [LevelWidth-1:0]  level_i;
  logic                   cim_valid_o;
  logic                   cim_ready_i;
  logic [HVDimension-1:0] cim_o;

  // Requester / result consumer side
  modport master (
    output req_valid_i, seed_hv_i, level_i, cim_ready_i,
    input  req_ready_o, cim_valid_o, cim_o
  );

  // Sequencer side
  modport slave (
    input  req_valid_i, seed_hv_i, level_i, cim_ready_i,
    output req_ready_o, cim_valid_o, cim_o
  );
endinterface

// File: rtl/cim_seq.sv
// Sequential Continuous Item Memory generator: builds the level-L hypervector
// by flipping up to FlipsPerCycle stride-spaced bits per clock, starting from
// the cached previous vector when the seed is unchanged.
module cim_seq #(
  parameter int unsigned HVDimension   = 512,
  parameter int unsigned SeedWidth     = 32,
  parameter int unsigned NumCimLevels  = HVDimension / 2,
  parameter int unsigned FlipStride    = 2,
  parameter int unsigned FlipOffset    = 1,
  parameter int unsigned FlipsPerCycle = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  cim_seq_if.slave   bus
);

  localparam int unsigned LevelWidth = $clog2(NumCimLevels);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FLIP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Parameter sanity: every flip position must land inside the vector
  if (FlipOffset + (NumCimLevels - 2) * FlipStride >= HVDimension) begin : g_chk_span
    $error("cim_seq: flip positions exceed HVDimension");
  end
  if (FlipsPerCycle == 0 || FlipsPerCycle > NumCimLevels - 1) begin : g_chk_fpc
    $error("cim_seq: FlipsPerCycle out of range");
  end

  logic [1:0]             r_state;
  logic [LevelWidth-1:0]  r_cur_level;
  logic [LevelWidth-1:0]  r_target;
  logic [SeedWidth-1:0]   r_seed;
  logic                   r_cache_valid;
  logic [HVDimension-1:0] r_work;
  logic                   r_req_ready;
  logic                   r_cim_valid;

  logic [1:0]             w_state_nxt;
  logic [LevelWidth-1:0]  w_cur_nxt;
  logic [LevelWidth-1:0]  w_target_nxt;
  logic [SeedWidth-1:0]   w_seed_nxt;
  logic                   w_cache_nxt;
  logic [HVDimension-1:0] w_work_nxt;
  logic                   w_valid_nxt;

  logic [HVDimension-1:0] w_base;
  logic [LevelWidth-1:0]  w_lvl;
  logic                   w_hit;
  logic                   w_up;
  logic [LevelWidth-1:0]  w_diff;
  logic [LevelWidth-1:0]  w_n;
  logic [LevelWidth-1:0]  w_lo;
  logic [LevelWidth-1:0]  w_hi;
  logic [LevelWidth-1:0]  w_step_level;
  logic [HVDimension-1:0] w_mask;

  // Base hypervector, combinational from the live seed input
  ca90_hier_base #(
    .SeedWidth   (SeedWidth),
    .HVDimension (HVDimension)
  ) u_base (
    .i_seed (bus.seed_hv_i),
    .o_base (w_base)
  );

  // Clamp out-of-range levels; only reachable for non-power-of-two level counts
  if (NumCimLevels == (1 << LevelWidth)) begin : g_noclamp
    assign w_lvl = bus.level_i;
  end else begin : g_clamp
    assign w_lvl = (bus.level_i > LevelWidth'(NumCimLevels - 1))
                 ? LevelWidth'(NumCimLevels - 1) : bus.level_i;
  end

  assign w_hit = r_cache_valid && (bus.seed_hv_i == r_seed);

  // This cycle's flip window [w_lo, w_hi) in flip-index space
  assign w_up         = (r_target > r_cur_level);
  assign w_diff       = w_up ? (r_target - r_cur_level) : (r_cur_level - r_target);
  assign w_n          = (w_diff > LevelWidth'(FlipsPerCycle)) ? LevelWidth'(FlipsPerCycle) : w_diff;
  assign w_lo         = w_up ? r_cur_level : (r_cur_level - w_n);
  assign w_hi         = w_up ? (r_cur_level + w_n) : r_cur_level;
  assign w_step_level = w_up ? w_hi : w_lo;

  // Each flip-position bit toggles when its flip index lies in the window
  for (genvar b = 0; b < HVDimension; b++) begin : g_mask
    if ((b >= FlipOffset) && (((b - FlipOffset) % FlipStride) == 0) &&
        (((b - FlipOffset) / FlipStride) <= NumCimLevels - 2)) begin : g_pos
      localparam logic [LevelWidth-1:0] J = LevelWidth'((b - FlipOffset) / FlipStride);
      assign w_mask[b] = (w_lo <= J) && (w_hi > J);
    end else begin : g_none
      assign w_mask[b] = 1'b0;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_cur_level;
    w_target_nxt = r_target;
    w_seed_nxt   = r_seed;
    w_cache_nxt  = r_cache_valid;
    w_work_nxt   = r_work;
    w_valid_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          w_target_nxt = w_lvl;
          if (w_hit) begin
            w_state_nxt = (w_lvl != r_cur_level) ? S_FLIP : S_DONE;
          end else begin
            w_work_nxt  = w_base;
            w_cur_nxt   = '0;
            w_seed_nxt  = bus.seed_hv_i;
            w_cache_nxt = 1'b1;
            w_state_nxt = (w_lvl != '0) ? S_FLIP : S_DONE;
          end
        end
      end
      S_FLIP: begin
        w_work_nxt = r_work ^ w_mask;
        w_cur_nxt  = w_step_level;
        if (w_step_level == r_target) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (r_cim_valid && bus.cim_ready_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, cache and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_cur_level   <= '0;
      r_target      <= '0;
      r_seed        <= '0;
      r_cache_valid <= 1'b0;
      r_work        <= '0;
      r_req_ready   <= 1'b1;
      r_cim_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur_level   <= w_cur_nxt;
      r_target      <= w_target_nxt;
      r_seed        <= w_seed_nxt;
      r_cache_valid <= w_cache_nxt;
      r_work        <= w_work_nxt;
      r_req_ready   <= (w_state_nxt == S_IDLE);
      r_cim_valid   <= w_valid_nxt;
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.cim_valid_o = r_cim_valid;
  assign bus.cim_o       = r_work;

endmodule

// Hierarchical CA90 base: each stage appends one rule-90 step (cyclic) of
// everything generated so far, doubling the width until HVDimension is covered.
module ca90_hier_base #(
  parameter int unsigned SeedWidth   = 32,
  parameter int unsigned HVDimension = 512
) (
  input  logic [SeedWidth-1:0]   i_seed,
  output logic [HVDimension-1:0] o_base
);

  localparam int unsigned NumStages = $clog2((HVDimension + SeedWidth - 1) / SeedWidth);

  // One doubling stage: {ca90(prev), prev}
  for (genvar s = 0; s < NumStages; s++) begin : g_stg
    localparam int unsigned W = SeedWidth << s;
    logic [W-1:0]   w_prev;
    logic [2*W-1:0] w_v;
    if (s == 0) begin : g_first
      assign w_prev = i_seed;
    end else begin : g_next
      assign w_prev = g_stg[s-1].w_v;
    end
    assign w_v = {({w_prev[W-2:0], w_prev[W-1]} ^ {w_prev[0], w_prev[W-1:1]}), w_prev};
  end

  if (NumStages == 0) begin : g_seed_only
    assign o_base = i_seed[HVDimension-1:0];
  end else begin : g_out
    assign o_base = g_stg[NumStages-1].w_v[HVDimension-1:0];
  end

endmodule
